// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_pkg                                                   |
// | Brief   : Shared UART constants and arbiter state encodings.         |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package uart_pkg;

  // Transmitter timing, from which the acknowledge timeout is sized.
  localparam int UART_DELAY_FRAMES    = 234;
  localparam int UART_FRAME_BITS      = 10;
  localparam int UART_DEBOUNCE_CYCLES = 250000;
  localparam int UART_BIT_PER_WORD    = 7;

  localparam int UART_DATA_WIDTH  = UART_BIT_PER_WORD + 1;
  localparam int UART_ACK_TIMEOUT = 300000;

  typedef enum logic [1:0] {
    UART_ARB_IDLE     = 2'd0,
    UART_ARB_STROBE   = 2'd1,
    UART_ARB_WAIT_ACK = 2'd2,
    UART_ARB_WAIT_REL = 2'd3
  } uart_arb_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_select                                                  |
// | Brief   : Round-robin priority picker with packet-lock override.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic               lock_i,
  input  logic [IDX_W-1:0]   owner_i,
  output logic [NUM_REQ-1:0] sel_onehot_o,
  output logic [IDX_W-1:0]   sel_idx_o,
  output logic               sel_any_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    sel_onehot_o = '0;
    sel_idx_o    = '0;
    sel_any_o    = 1'b0;
    cand         = '0;
    if (lock_i) begin
      if (valid_i[owner_i]) begin
        sel_onehot_o[owner_i] = 1'b1;
        sel_idx_o             = owner_i;
        sel_any_o             = 1'b1;
      end
    end else begin
      // Search starts one past the last winner so it gets lowest priority.
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
        if (!sel_any_o && valid_i[cand]) begin
          sel_onehot_o[cand] = 1'b1;
          sel_idx_o          = cand;
          sel_any_o          = 1'b1;
        end
      end
    end
  end

endmodule : rr_select
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_tx_arbiter                                            |
// | Brief   : Round-robin byte arbiter feeding one edge-triggered uart_tx.|
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = UART_DATA_WIDTH,
  parameter int ACK_TIMEOUT = UART_ACK_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_data_ready,
  input  logic                          tx_sampled,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          err_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  uart_arb_state_e       state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_data_ready_q, tx_data_ready_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic                  lock_q, lock_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_timeout_q, err_timeout_d;

  logic [NUM_REQ-1:0]    sel_onehot;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_any;

  // The lock owner is always the last winner, so rr_ptr doubles as owner.
  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .valid_i      (req_valid),
    .ptr_i        (rr_ptr_q),
    .lock_i       (lock_q),
    .owner_i      (rr_ptr_q),
    .sel_onehot_o (sel_onehot),
    .sel_idx_o    (sel_idx),
    .sel_any_o    (sel_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= UART_ARB_IDLE;
      tx_data_q       <= '0;
      tx_data_ready_q <= 1'b0;
      grant_q         <= '0;
      lock_q          <= 1'b0;
      rr_ptr_q        <= IDX_W'(NUM_REQ - 1);
      cnt_q           <= '0;
      err_timeout_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      tx_data_q       <= tx_data_d;
      tx_data_ready_q <= tx_data_ready_d;
      grant_q         <= grant_d;
      lock_q          <= lock_d;
      rr_ptr_q        <= rr_ptr_d;
      cnt_q           <= cnt_d;
      err_timeout_q   <= err_timeout_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    tx_data_d       = tx_data_q;
    tx_data_ready_d = tx_data_ready_q;
    grant_d         = grant_q;
    lock_d          = lock_q;
    rr_ptr_d        = rr_ptr_q;
    cnt_d           = cnt_q;
    err_timeout_d   = 1'b0;
    unique case (state_q)
      UART_ARB_IDLE: begin
        tx_data_ready_d = 1'b0;
        if (sel_any) begin
          tx_data_d = req_data[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
          grant_d   = sel_onehot;
          rr_ptr_d  = sel_idx;
          lock_d    = ~req_last[sel_idx];
          state_d   = UART_ARB_STROBE;
        end
      end
      UART_ARB_STROBE: begin
        // tx_sampled is deliberately ignored here: a high level is stale.
        tx_data_ready_d = 1'b1;
        cnt_d           = '0;
        state_d         = UART_ARB_WAIT_ACK;
      end
      UART_ARB_WAIT_ACK: begin
        if (tx_sampled) begin
          tx_data_ready_d = 1'b0;
          state_d         = UART_ARB_WAIT_REL;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          err_timeout_d   = 1'b1;
          tx_data_ready_d = 1'b0;
          lock_d          = 1'b0;
          grant_d         = '0;
          state_d         = UART_ARB_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      UART_ARB_WAIT_REL: begin
        tx_data_ready_d = 1'b0;
        if (!tx_sampled) begin
          state_d = UART_ARB_IDLE;
          if (!lock_q) grant_d = '0;
        end
      end
      default: state_d = UART_ARB_IDLE;
    endcase
  end

  assign req_ready     = (state_q == UART_ARB_IDLE) ? sel_onehot : '0;
  assign tx_data       = tx_data_q;
  assign tx_data_ready = tx_data_ready_q;
  assign grant         = grant_q;
  assign busy          = (state_q != UART_ARB_IDLE);
  assign err_timeout   = err_timeout_q;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_uart_tx_arbiter                                         |
// | Brief   : Scoreboard bench with a small uart_tx model and receiver.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 200;
  localparam int DELAY_FRAMES = 4;
  localparam int DEBOUNCE = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid, req_last, req_ready, grant;
  logic [NR*DW-1:0] req_data;
  logic [DW-1:0]   tx_data;
  logic            tx_data_ready, busy, err_timeout;
  wire             tx_sampled;

  logic ovr, ovr_val, m_samp, line, rx_busy;
  assign tx_sampled = ovr ? ovr_val : m_samp;

  int errors = 0;
  int checks = 0;
  int dr_rises = 0;
  logic dr_prev = 1'b0;

  logic [8:0] rq [NR][$];
  logic [7:0] exp_bytes[$];
  int         exp_grant[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .tx_data(tx_data),
    .tx_data_ready(tx_data_ready), .tx_sampled(tx_sampled), .grant(grant),
    .busy(busy), .err_timeout(err_timeout)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(int r, logic [7:0] d, logic l, bit serial);
    rq[r].push_back({l, d});
    if (serial) exp_bytes.push_back(d);
  endtask

  function automatic bit cond(int w);
    case (w)
      0: return req_ready != '0;
      1: return tx_data_ready === 1'b1;
      2: return grant == '0 && !busy;
      3: return exp_bytes.size() == 0 && !rx_busy && !busy;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(int w, int lim, string tag);
    int n = 0;
    while (!cond(w) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(cond(w)), 32'd1);
  endtask

  // Requester driver: pops a byte after its handshake, presents queue heads.
  initial begin
    logic [NR-1:0] hs;
    req_valid = '0; req_last = '0; req_data = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (hs[i] && !rst && rq[i].size() > 0) void'(rq[i].pop_front());
        req_valid[i] = rq[i].size() > 0;
        if (rq[i].size() > 0) {req_last[i], req_data[i*DW +: DW]} = rq[i][0];
      end
    end
  end

  // Accept monitor: checks grant order against expectations.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_data_ready && !dr_prev) dr_rises++;
      dr_prev = tx_data_ready;
      if (!rst && |(req_valid & req_ready)) begin
        int idx = -1;
        for (int i = 0; i < NR; i++) if (req_valid[i] & req_ready[i]) idx = i;
        if (exp_grant.size() == 0) chk("grant_unexpected", 32'(idx), 32'hFFFF_FFFF);
        else chk("grant_order", 32'(idx), 32'(exp_grant.pop_front()));
      end
    end
  end

  // uart_tx model: latches after debounce, sampled high during start bit.
  initial begin
    logic [7:0] b;
    m_samp = 1'b0; line = 1'b1;
    forever begin
      @(posedge clk);
      if (tx_data_ready && !ovr && !rst) begin
        repeat (DEBOUNCE) @(posedge clk);
        if (tx_data_ready && !ovr) begin
          b = tx_data;
          #1; m_samp = 1'b1; line = 1'b0;
          for (int i = 0; i < 8; i++) begin
            repeat (DELAY_FRAMES) @(posedge clk);
            #1;
            if (i == 0) m_samp = 1'b0;
            line = b[i];
          end
          repeat (DELAY_FRAMES) @(posedge clk);
          #1; line = 1'b1;
          repeat (DELAY_FRAMES) @(posedge clk);
        end
      end
    end
  end

  // Serial receiver: decodes frames and pops the byte scoreboard.
  initial begin
    logic [7:0] rb;
    rx_busy = 1'b0;
    forever begin
      @(posedge clk);
      if (line === 1'b0) begin
        rx_busy = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DELAY_FRAMES) @(posedge clk);
          rb[i] = line;
        end
        repeat (DELAY_FRAMES) @(posedge clk);
        chk("rx_stop_bit", 32'(line), 32'd1);
        if (exp_bytes.size() == 0) chk("rx_unexpected", 32'(rb), 32'hFFFF_FFFF);
        else chk("rx_byte", 32'(rb), 32'(exp_bytes.pop_front()));
        rx_busy = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r0;
    rst = 1'b1; ovr = 1'b0; ovr_val = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_data_ready", 32'(tx_data_ready), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    rst = 1'b0;

    // Fairness from reset: req0 wins first, then strict rotation.
    exp_grant = '{0, 1, 2, 3, 0};
    send(0, 8'hA0, 1'b1, 1'b1); send(1, 8'hA1, 1'b1, 1'b1);
    send(2, 8'hA2, 1'b1, 1'b1); send(3, 8'hA3, 1'b1, 1'b1);
    send(0, 8'hA0, 1'b1, 1'b1);
    wait_for(3, 3000, "fair_done");
    chk("fair_grants_left", 32'(exp_grant.size()), 32'd0);

    // Single byte with accept/strobe timing.
    exp_grant.push_back(0);
    send(0, 8'h55, 1'b1, 1'b1);
    wait_for(0, 100, "single_ready_seen");
    chk("single_req_ready", 32'(req_ready), 32'b0001);
    @(negedge clk);
    chk("single_ready_1cyc", 32'(req_ready), 32'd0);
    chk("single_tx_data", 32'(tx_data), 32'h55);
    chk("single_strobe_dr", 32'(tx_data_ready), 32'd0);
    chk("single_grant", 32'(grant), 32'b0001);
    chk("single_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("single_dr_rise", 32'(tx_data_ready), 32'd1);
    wait_for(2, 200, "single_grant_release");
    wait_for(3, 300, "single_done");

    // Lock: req1 packet of three goes out uninterrupted, then req2, req0.
    exp_grant = '{1, 1, 1, 2, 0};
    send(1, 8'hB0, 1'b0, 1'b1); send(1, 8'hB1, 1'b0, 1'b1);
    send(1, 8'hB2, 1'b1, 1'b1); send(2, 8'hC2, 1'b1, 1'b1);
    send(0, 8'hC0, 1'b1, 1'b1);
    wait_for(3, 3000, "lock_done");
    chk("lock_grants_left", 32'(exp_grant.size()), 32'd0);

    // Timeout: no acknowledge ever arrives.
    ovr = 1'b1; ovr_val = 1'b0;
    exp_grant.push_back(3);
    send(3, 8'h3C, 1'b1, 1'b0);
    wait_for(1, 100, "to_dr_high");
    n = 0;
    while (!err_timeout && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("to_latency", 32'(n), 32'(TO));
    chk("to_dr_low", 32'(tx_data_ready), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_grant", 32'(grant), 32'd0);
    @(negedge clk);
    chk("to_pulse_width", 32'(err_timeout), 32'd0);
    ovr = 1'b0;
    exp_grant.push_back(3);
    send(3, 8'h3D, 1'b1, 1'b1);
    wait_for(3, 300, "to_retry_done");

    // Reset while waiting for acknowledge.
    ovr = 1'b1; ovr_val = 1'b0;
    exp_grant.push_back(0);
    send(0, 8'h11, 1'b1, 1'b0);
    wait_for(1, 100, "rstmid_dr_high");
    rst = 1'b1;
    #1;
    chk("rstmid_dr", 32'(tx_data_ready), 32'd0);
    chk("rstmid_grant", 32'(grant), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0; ovr = 1'b0;
    exp_grant.push_back(0); exp_grant.push_back(2);
    send(0, 8'h22, 1'b1, 1'b1); send(2, 8'h33, 1'b1, 1'b1);
    wait_for(3, 600, "rstmid_done");

    // Stale sampled: high through accept and strobe, dropped in WAIT_ACK.
    ovr = 1'b1; ovr_val = 1'b1;
    r0 = dr_rises;
    exp_grant.push_back(1);
    send(1, 8'h77, 1'b1, 1'b0);
    wait_for(0, 100, "stale_ready_seen");
    @(negedge clk);
    chk("stale_strobe_dr", 32'(tx_data_ready), 32'd0);
    @(negedge clk);
    chk("stale_dr_rise", 32'(tx_data_ready), 32'd1);
    ovr_val = 1'b0;
    repeat (8) @(negedge clk);
    chk("stale_hold_dr", 32'(tx_data_ready), 32'd1);
    chk("stale_hold_busy", 32'(busy), 32'd1);
    ovr_val = 1'b1;
    @(negedge clk);
    chk("stale_ack_dr", 32'(tx_data_ready), 32'd0);
    chk("stale_rel_busy", 32'(busy), 32'd1);
    ovr_val = 1'b0;
    @(negedge clk);
    chk("stale_idle", 32'(busy), 32'd0);
    chk("stale_grant", 32'(grant), 32'd0);
    chk("stale_single_strobe", 32'(dr_rises - r0), 32'd1);
    ovr = 1'b0;

    repeat (5) @(negedge clk);
    chk("end_grants_left", 32'(exp_grant.size()), 32'd0);
    chk("end_bytes_left", 32'(exp_bytes.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_tx_arbiter
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance among NUM_REQ byte requesters using round-robin arbitration, with optional packet lock.
- Drives the transmitter's edge-triggered data_ready input and holds tx_data stable until the transmitter confirms capture on its sampled output.
- Sits between the command/telemetry producers and uart_tx in the FPGA comm top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, byte width; must equal uart_tx BIT_PER_WORD+1.
- ACK_TIMEOUT, 300000, max cycles from strobe to tx_sampled rise; must exceed uart_tx debounce plus one frame.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_last  in  NUM_REQ  byte is last of packet; releases lock
- req_data  in  NUM_REQ*DATA_WIDTH  requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  one-hot accept; transfer when valid&ready
- tx_data  out  DATA_WIDTH  to uart_tx data
- tx_data_ready  out  1  to uart_tx data_ready (rising edge = new byte)
- tx_sampled  in  1  from uart_tx sampled (high during start bit)
- grant  out  NUM_REQ  one-hot current owner, 0 when idle and unlocked
- busy  out  1  state != IDLE
- err_timeout  out  1  one-cycle pulse on ack timeout

Behaviour:
- Reset (async, immediate): state=IDLE, tx_data=0, tx_data_ready=0, grant=0, req_ready=0, err_timeout=0, lock=0, rr_ptr=NUM_REQ-1 (req 0 wins first).
- States: IDLE, STROBE, WAIT_ACK, WAIT_REL.
- IDLE: tx_data_ready=0.
  - If unlocked: select the first i with req_valid[i], searching from rr_ptr+1 modulo NUM_REQ.
  - If locked: only the lock owner is eligible.
  - req_ready is combinational and one-hot for the selected requester in IDLE only.
  - On transfer: tx_data<=req_data[i], grant<=onehot(i), rr_ptr<=i, lock<=~req_last[i], go to STROBE.
  - No eligible valid: stay in IDLE. Locked with owner not valid: wait indefinitely and keep grant.
- STROBE: tx_data_ready<=1; clear timeout counter; go to WAIT_ACK. Latency from accept to tx_data_ready rising is 1 cycle.
- WAIT_ACK: hold tx_data_ready=1 and tx_data stable.
  - tx_sampled==1: tx_data_ready<=0, go to WAIT_REL.
  - Counter reaches ACK_TIMEOUT-1 first: pulse err_timeout, tx_data_ready<=0, clear lock and grant, go to IDLE. The byte is dropped.
- WAIT_REL: tx_data_ready=0.
  - When tx_sampled==0: go to IDLE; grant<=0 if unlocked, else keep.
  - This guarantees at least one low cycle of tx_data_ready before the next rising edge.
- tx_sampled already high on STROBE entry (stale): ignored. Only a high level seen in WAIT_ACK counts.
- tx_data changes only on an IDLE accept.
- Simultaneous valids: round-robin order from rr_ptr+1.
- Lock: held across bytes until a byte with req_last=1 is accepted.
- Timeout counter width: clog2(ACK_TIMEOUT+1).
- Reset mid-frame: returns to IDLE with tx_data_ready low. A byte already latched by uart_tx still transmits; this is not tracked.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings (UART_ARB_IDLE..WAIT_REL);
  - the default DATA_WIDTH;
  - the default ACK_TIMEOUT and the uart_tx DELAY_FRAMES/debounce constants it is derived from.
- One natural sub-module, rr_select: combinational round-robin priority picker (valid vector, pointer, lock, owner → one-hot, index).

Test Plan:
Benches use a uart_tx model with DELAY_FRAMES=4 and debounce 16, ACK_TIMEOUT=200.
- Single byte: req_valid=0001, data0=0x55, last=1 → req_ready[0] for 1 cycle; tx_data=0x55; tx_data_ready rises 1 cycle later and stays high until sampled; serial line shows 0x55; grant returns to 0.
- Fairness: all four valid continuously with last=1, data 0xA0..0xA3 → grants in order 0,1,2,3,0, each byte transmitted intact.
- Lock: req1 sends 3 bytes (last on the 3rd) while req0 and req2 are valid → the three req1 bytes go out back-to-back with no interleaving, then req2 is granted (rr from 1).
- Timeout: tx_sampled tied 0, req3 valid → err_timeout pulses exactly 200 cycles after STROBE; state returns to IDLE; tx_data_ready=0; req3 is re-granted on the next arbitration.
- Reset mid-operation: assert rst in WAIT_ACK → same cycle tx_data_ready=0, grant=0, busy=0; after release, req0 wins a tie against req2.
- Stale sampled: tx_sampled held high through accept then dropped and re-raised → no advance until tx_sampled is high while in WAIT_ACK; no double strobe.
